// File: rtl/reg_bank_pkg.sv
// Shared opcodes and CLEAR-sweep state encoding for the ALU operand register bank.
package reg_bank_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_SWAP  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    function automatic logic op_reserved(input logic [2:0] op);
        return op > OP_CLEAR;
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Command/read-port bundle between the ALU sequencer (master) and the register bank (slave).
interface reg_bank_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [SEL_W-1:0] rd_sel;
    logic [SEL_W-1:0] rs_sel;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] Y;
    logic [SEL_W-1:0] a_sel;
    logic [SEL_W-1:0] b_sel;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_op, rd_sel, rs_sel, data_in, Y, a_sel, b_sel,
        input  cmd_ready, A, B, busy, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, rd_sel, rs_sel, data_in, Y, a_sel, b_sel,
        output cmd_ready, A, B, busy, cmd_err
    );

endinterface

// File: rtl/reg_bank_sweep.sv
// CLEAR sequencer: walks the register index from 0 to NUM_REGS-1, one register per cycle.
module reg_bank_sweep #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_clr_en,
    output logic [SEL_W-1:0] o_clr_idx
);
    import reg_bank_pkg::*;

    logic [0:0]       r_state;
    logic [SEL_W-1:0] r_cnt;
    logic             w_last;

    assign w_last    = (r_cnt == SEL_W'(NUM_REGS - 1));
    assign o_busy    = (r_state == ST_SWEEP);
    assign o_clr_en  = o_busy;
    assign o_clr_idx = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (i_start) begin
                r_state <= ST_SWEEP;
                r_cnt   <= '0;
            end
        end else if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + SEL_W'(1);
        end
    end

endmodule

// File: rtl/reg_bank.sv
// NUM_REGS x WIDTH operand register bank: two combinational read ports, LOAD/STORE/SWAP/CLEAR
// commands over a valid/ready handshake, one-cycle write latency without read bypass.
module reg_bank #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
) (
    input logic        clk,
    input logic        reset,
    reg_bank_if.slave  bus
);
    import reg_bank_pkg::*;

    localparam int SEL_W = $clog2(NUM_REGS);

    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic             r_cmd_err;

    logic             w_accept;
    logic             w_busy;
    logic             w_clr_en;
    logic [SEL_W-1:0] w_clr_idx;
    logic             w_rd_ok;
    logic             w_rs_ok;
    logic             w_a_ok;
    logic             w_b_ok;
    logic             w_err;

    assign w_accept = bus.cmd_valid && bus.cmd_ready;
    assign w_rd_ok  = int'(bus.rd_sel) < NUM_REGS;
    assign w_rs_ok  = int'(bus.rs_sel) < NUM_REGS;
    assign w_a_ok   = int'(bus.a_sel) < NUM_REGS;
    assign w_b_ok   = int'(bus.b_sel) < NUM_REGS;

    reg_bank_sweep #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_sweep (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_accept && (bus.cmd_op == OP_CLEAR)),
        .o_busy    (w_busy),
        .o_clr_en  (w_clr_en),
        .o_clr_idx (w_clr_idx)
    );

    // Only selects the opcode actually uses are range-checked.
    always_comb begin
        w_err = 1'b0;
        case (bus.cmd_op)
            OP_LOAD, OP_STORE: w_err = !w_rd_ok;
            OP_SWAP:           w_err = !(w_rd_ok && w_rs_ok);
            default:           w_err = op_reserved(bus.cmd_op);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_accept && w_err;
            // Sweep and command writes are exclusive: ready is low for the whole sweep.
            if (w_clr_en) begin
                r_regs[w_clr_idx] <= '0;
            end else if (w_accept && !w_err) begin
                case (bus.cmd_op)
                    OP_LOAD:  r_regs[bus.rd_sel] <= bus.data_in;
                    OP_STORE: r_regs[bus.rd_sel] <= bus.Y;
                    OP_SWAP: begin
                        r_regs[bus.rd_sel] <= r_regs[bus.rs_sel];
                        r_regs[bus.rs_sel] <= r_regs[bus.rd_sel];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.cmd_ready = !w_busy;
    assign bus.busy      = w_busy;
    assign bus.cmd_err   = r_cmd_err;
    assign bus.A         = w_a_ok ? r_regs[bus.a_sel] : '0;
    assign bus.B         = w_b_ok ? r_regs[bus.b_sel] : '0;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: vector table through a scoreboard queue, then CLEAR,
// reset and error corner sequences (second instance at NUM_REGS=3 for out-of-range selects).
module tb_reg_bank;
    import reg_bank_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    reg_bank_if #(.WIDTH(8), .NUM_REGS(4)) bus ();
    reg_bank_if #(.WIDTH(8), .NUM_REGS(3)) bus3 ();

    reg_bank #(.WIDTH(8), .NUM_REGS(4)) dut  (.clk(clk), .reset(reset), .bus(bus));
    reg_bank #(.WIDTH(8), .NUM_REGS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] op;
        logic [1:0] rd, rs;
        logic [7:0] d, y;
        logic [1:0] as, bs;
        logic [7:0] ea, eb;
        logic       ee;
    } vec_t;

    typedef struct {
        logic [7:0] a, b;
        logic       e;
    } exp_t;

    vec_t tbl [13];
    exp_t sbq [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cmd(input logic v, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [7:0] d, input logic [7:0] y);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.rd_sel    = rd;
        bus.rs_sel    = rs;
        bus.data_in   = d;
        bus.Y         = y;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all(input logic [7:0] val);
        for (int r = 0; r < 4; r++) begin
            cmd(1'b1, OP_LOAD, 2'(r), 2'd0, val, 8'h00);
            tick();
        end
        cmd(1'b0, OP_NOP, 2'd0, 2'd0, 8'h00, 8'h00);
    endtask

    task automatic chk_all_zero(input string nm);
        for (int r = 0; r < 4; r += 2) begin
            bus.a_sel = 2'(r);
            bus.b_sel = 2'(r + 1);
            #1;
            chk($sformatf("%s r%0d", nm, r), bus.A, 8'h00);
            chk($sformatf("%s r%0d", nm, r + 1), bus.B, 8'h00);
        end
    endtask

    initial begin
        exp_t e;

        //            v     op        rd    rs    d      y      as    bs    eA     eB     err
        tbl[0]  = '{1'b1, OP_LOAD,  2'd2, 2'd0, 8'h5A, 8'h00, 2'd2, 2'd0, 8'h5A, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, OP_STORE, 2'd3, 2'd0, 8'hEE, 8'hC3, 2'd2, 2'd3, 8'h5A, 8'hC3, 1'b0};
        tbl[2]  = '{1'b1, OP_LOAD,  2'd0, 2'd0, 8'h11, 8'h99, 2'd0, 2'd3, 8'h11, 8'hC3, 1'b0};
        tbl[3]  = '{1'b1, OP_LOAD,  2'd1, 2'd0, 8'h22, 8'h00, 2'd0, 2'd1, 8'h11, 8'h22, 1'b0};
        tbl[4]  = '{1'b1, OP_SWAP,  2'd0, 2'd1, 8'h00, 8'h00, 2'd0, 2'd1, 8'h22, 8'h11, 1'b0};
        tbl[5]  = '{1'b1, OP_SWAP,  2'd1, 2'd1, 8'h00, 8'h00, 2'd0, 2'd1, 8'h22, 8'h11, 1'b0};
        tbl[6]  = '{1'b1, OP_NOP,   2'd2, 2'd0, 8'hAB, 8'hCD, 2'd2, 2'd3, 8'h5A, 8'hC3, 1'b0};
        tbl[7]  = '{1'b1, 3'd6,     2'd0, 2'd1, 8'hFF, 8'hFF, 2'd0, 2'd1, 8'h22, 8'h11, 1'b1};
        tbl[8]  = '{1'b1, OP_NOP,   2'd0, 2'd0, 8'h00, 8'h00, 2'd0, 2'd1, 8'h22, 8'h11, 1'b0};
        tbl[9]  = '{1'b0, OP_STORE, 2'd2, 2'd0, 8'h00, 8'h0F, 2'd2, 2'd3, 8'h5A, 8'hC3, 1'b0};
        tbl[10] = '{1'b1, OP_SWAP,  2'd3, 2'd2, 8'h00, 8'h00, 2'd2, 2'd3, 8'hC3, 8'h5A, 1'b0};
        tbl[11] = '{1'b1, 3'd5,     2'd2, 2'd0, 8'h77, 8'h00, 2'd2, 2'd3, 8'hC3, 8'h5A, 1'b1};
        tbl[12] = '{1'b1, 3'd7,     2'd3, 2'd0, 8'h77, 8'h77, 2'd2, 2'd3, 8'hC3, 8'h5A, 1'b1};

        cmd(1'b0, OP_NOP, 2'd0, 2'd0, 8'h00, 8'h00);
        bus.a_sel = 2'd0;
        bus.b_sel = 2'd1;
        bus3.cmd_valid = 1'b0;
        bus3.cmd_op    = OP_NOP;
        bus3.rd_sel    = 2'd0;
        bus3.rs_sel    = 2'd0;
        bus3.data_in   = 8'h00;
        bus3.Y         = 8'h00;
        bus3.a_sel     = 2'd0;
        bus3.b_sel     = 2'd0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst A", bus.A, 8'h00);
        chk("rst B", bus.B, 8'h00);
        chk("rst ready", bus.cmd_ready, 1'b1);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst err", bus.cmd_err, 1'b0);

        // Vector table through the scoreboard.
        for (int i = 0; i < 13; i++) begin
            cmd(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].d, tbl[i].y);
            bus.a_sel = tbl[i].as;
            bus.b_sel = tbl[i].bs;
            e.a = tbl[i].ea;
            e.b = tbl[i].eb;
            e.e = tbl[i].ee;
            sbq.push_back(e);
            tick();
            e = sbq.pop_front();
            chk($sformatf("vec%0d A", i), bus.A, e.a);
            chk($sformatf("vec%0d B", i), bus.B, e.b);
            chk($sformatf("vec%0d err", i), bus.cmd_err, e.e);
        end
        cmd(1'b0, OP_NOP, 2'd0, 2'd0, 8'h00, 8'h00);
        tick();
        chk("err drops", bus.cmd_err, 1'b0);

        // Reset with preloaded registers.
        load_all(8'hA5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("rst2");
        chk("rst2 ready", bus.cmd_ready, 1'b1);
        chk("rst2 busy", bus.busy, 1'b0);

        // CLEAR sweep with a held LOAD behind it.
        load_all(8'hFF);
        cmd(1'b1, OP_CLEAR, 2'd0, 2'd0, 8'h00, 8'h00);
        tick();
        chk("clr busy0", bus.busy, 1'b1);
        chk("clr ready0", bus.cmd_ready, 1'b0);
        cmd(1'b1, OP_LOAD, 2'd0, 2'd0, 8'h77, 8'h00);
        for (int j = 1; j <= 4; j++) begin
            tick();
            bus.a_sel = 2'(j - 1);
            bus.b_sel = 2'(j);
            #1;
            chk($sformatf("clr r%0d zero", j - 1), bus.A, 8'h00);
            if (j < 4) chk($sformatf("clr r%0d kept", j), bus.B, 8'hFF);
            chk($sformatf("clr busy%0d", j), bus.busy, (j < 4) ? 1'b1 : 1'b0);
            chk($sformatf("clr ready%0d", j), bus.cmd_ready, (j < 4) ? 1'b0 : 1'b1);
        end
        tick();
        cmd(1'b0, OP_NOP, 2'd0, 2'd0, 8'h00, 8'h00);
        bus.a_sel = 2'd0;
        #1;
        chk("held load", bus.A, 8'h77);
        chk("held load busy", bus.busy, 1'b0);

        // Reset two cycles into a sweep.
        load_all(8'hFF);
        cmd(1'b1, OP_CLEAR, 2'd0, 2'd0, 8'h00, 8'h00);
        tick();
        cmd(1'b0, OP_NOP, 2'd0, 2'd0, 8'h00, 8'h00);
        repeat (2) tick();
        chk("mid busy", bus.busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid ready", bus.cmd_ready, 1'b1);
        chk("mid busy off", bus.busy, 1'b0);
        chk_all_zero("mid");

        // Out-of-range selects on the 3-register instance.
        bus3.cmd_valid = 1'b1;
        bus3.cmd_op    = OP_LOAD;
        bus3.rd_sel    = 2'd0;
        bus3.data_in   = 8'h33;
        tick();
        chk("n3 load A", bus3.A, 8'h33);
        chk("n3 load err", bus3.cmd_err, 1'b0);
        bus3.rd_sel  = 2'd3;
        bus3.data_in = 8'hAA;
        bus3.b_sel   = 2'd3;
        tick();
        chk("n3 oor err", bus3.cmd_err, 1'b1);
        chk("n3 oor A", bus3.A, 8'h33);
        chk("n3 oor B", bus3.B, 8'h00);
        bus3.cmd_valid = 1'b0;
        tick();
        chk("n3 err pulse", bus3.cmd_err, 1'b0);
        bus3.cmd_valid = 1'b1;
        bus3.cmd_op    = OP_SWAP;
        bus3.rd_sel    = 2'd0;
        bus3.rs_sel    = 2'd3;
        tick();
        bus3.cmd_valid = 1'b0;
        chk("n3 swap err", bus3.cmd_err, 1'b1);
        chk("n3 swap A", bus3.A, 8'h33);
        bus3.a_sel = 2'd1;
        bus3.b_sel = 2'd2;
        #1;
        chk("n3 r1", bus3.A, 8'h00);
        chk("n3 r2", bus3.B, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
